edge_event_arbiter: RTL and testbench
=====================================

# edge_event_arbiter

Multi-channel rising-edge event collector and scheduler for slow external inputs such as push-buttons and switches. Each channel is synchronized, sampled on a shared sample tick, and edge-detected. Each detected rising edge is latched as a pending event. One pending event at a time is presented to a single downstream consumer over a valid/ready handshake, and a round-robin grant shares that consumer fairly among channels. The block sits between board inputs and the control FSMs that act on single-cycle "pressed" events.

## Interface
- N, 4: number of input channels (2..8).
- IW, 2: width of ev_id; must satisfy 2^IW >= N.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- tick  in  1  sample enable; sampling and edge detection occur only in cycles where tick=1.
- in  in  N  raw asynchronous channel inputs.
- ev_valid  out  1  event offered to the consumer; registered.
- ev_id  out  IW  channel index of the offered event; registered.
- ev_ready  in  1  consumer accepts the event when ev_valid=1 and ev_ready=1 in the same cycle.
- pend  out  N  pending-event flags, one per channel; registered.
- ovf  out  N  sticky overflow flags, one per channel; registered.
- ovf_clr  in  1  synchronous clear of all ovf bits.

## Operation
- **Synchronizer.** Two flops per channel, clocked every cycle: s1 <= in, s2 <= s1.
- **Sampler.** When tick=1, smp <= s2. When tick=0, smp holds.
- **Edge detection.** edge[i] = tick & s2[i] & ~smp[i].
  - smp resets to 0, so an input already high when reset is released yields one event at the first tick.
- **Accept condition.** acc[i] = ev_valid & ev_ready & (ev_id == i).
- **Pending update, per channel.**
  - edge=1, acc=0, pend=0: pend <= 1.
  - edge=1, acc=0, pend=1: pend stays 1 and ovf <= 1. The two events merge into one.
  - edge=1, acc=1: pend stays 1. The new event replaces the accepted one; no overflow.
  - edge=0, acc=1: pend <= 0.
- **Overflow clear.** ovf_clr=1 clears all ovf bits. If a set and ovf_clr occur in the same cycle for a channel, the set wins.
- **Arbiter pointer.** lg holds the last granted index and resets to N-1.
- **Grant search.** Start at (lg+1) mod N and increment with wrap-around. The first channel with pend=1 wins.
- **FSM states.**
  - IDLE: ev_valid=0. If any pend bit is 1, then ev_id <= winner, ev_valid <= 1, go to OFFER. Otherwise stay in IDLE.
  - OFFER: ev_valid=1. ev_id is held stable until acceptance.
    - On ev_ready=1: pend[ev_id] is cleared (per the update rules above), lg <= ev_id, ev_valid <= 0, go to IDLE.
    - On ev_ready=0: stay in OFFER. A new edge on the offered channel sets ovf for that channel.
- The arbiter reads only registered pend, so a channel just accepted is never re-granted from stale state.
- Index arithmetic is mod N on IW bits. Channel indices >= N are never produced.

## Timing
- **Reset values.** s1, s2, smp, pend, ovf = 0; ev_valid=0; ev_id=0; lg=N-1; state=IDLE.
- **Reset during OFFER.** The offer is dropped immediately, with no event delivered and no pend retained.
- **Latency.** With tick held at 1, in[i] sampled high at edge k gives:
  - pend[i]=1 after edge k+2;
  - ev_valid=1 with ev_id=i after edge k+3.
- **Throughput.** At most one event per 2 cycles: accept in OFFER, then one cycle in IDLE, then the next offer.
- **Input sampling window.** An input pulse shorter than the tick period that falls between ticks is not seen. An input held high across many ticks produces exactly one event.
- **Handshake rule.** Once ev_valid=1, ev_valid and ev_id must not change until the accepting cycle.

## Test plan
- **Reset:** assert rst with in=4'b1111 mid-stream → all outputs read 0 and state is IDLE. Release rst with tick=1 → four events delivered with ev_id 0,1,2,3 in order.
- **Single event:** tick=1, ev_ready=1, in[2] rises and is sampled at edge k → pend[2]=1 after k+2; ev_valid=1 with ev_id=2 after k+3; ev_valid=0 and pend[2]=0 after k+4.
- **Round robin:** pend=4'b1011 with lg=3 and ev_ready=1 → grants 0, 1, 3 in that order. Re-raising in[0] and in[1] after grant 1 → next grants are 3, 0, 1.
- **Backpressure and overflow:** ev_ready=0 while offering id 1; a second rising edge on in[1] → ev_id stays 1, ev_valid stays 1, ovf[1]=1. Assert ovf_clr → ovf=0. ovf_clr in the same cycle as a new overflow → ovf[1] stays 1.
- **Tick gating:** tick every 8 cycles; a 3-cycle in[3] pulse between ticks → no event. in[3] held high for 40 cycles → exactly one event with id 3.
- **Simultaneous edge and accept:** a new edge on in[0] sampled in the same cycle that id 0 is accepted → pend[0] stays 1, ovf[0]=0, and a second id-0 event is offered 2 cycles later.

Source files
------------

// File: rtl/edge_event_arbiter_if.sv
// Event-collector bus: board-side inputs, sample tick, consumer handshake and status flags.
// The master modport is the arbiter; the slave modport is the surrounding logic/consumer.
interface edge_event_arbiter_if #(
    parameter int N  = 4,
    parameter int IW = 2
);
    logic          tick;
    logic [N-1:0]  in;
    logic          ev_valid;
    logic [IW-1:0] ev_id;
    logic          ev_ready;
    logic [N-1:0]  pend;
    logic [N-1:0]  ovf;
    logic          ovf_clr;

    modport master (
        input  tick, in, ev_ready, ovf_clr,
        output ev_valid, ev_id, pend, ovf
    );

    modport slave (
        output tick, in, ev_ready, ovf_clr,
        input  ev_valid, ev_id, pend, ovf
    );
endinterface

// File: rtl/edge_event_arbiter.sv
// Rising-edge event collector: synchronize, tick-sample and edge-detect N inputs, latch
// pending events and hand them one at a time to a single consumer with round-robin fairness.
module edge_event_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    edge_event_arbiter_if.master  bus
);
    localparam int unsigned NU = N;

    typedef enum logic {IDLE, OFFER} state_t;

    state_t        st, st_nx;
    logic [N-1:0]  s1, s2, smp;
    logic [N-1:0]  pend, pend_nx, ovf, ovf_nx;
    logic [N-1:0]  edg, acc;
    logic [IW-1:0] lg, lg_nx, id, id_nx, win;
    logic          valid, valid_nx, any;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1   <= '0;
            s2   <= '0;
            smp  <= '0;
            pend <= '0;
            ovf  <= '0;
        end else begin
            s1   <= bus.in;
            s2   <= s1;
            if (bus.tick) smp <= s2;
            pend <= pend_nx;
            ovf  <= ovf_nx;
        end
    end

    // An edge landing on the accepted channel re-arms pend instead of overflowing.
    always_comb begin
        edg = {N{bus.tick}} & s2 & ~smp;
        acc = '0;
        for (int unsigned i = 0; i < NU; i++) begin
            acc[i] = valid & bus.ev_ready & (id == IW'(i));
        end
        pend_nx = edg | (pend & ~acc);
        ovf_nx  = (edg & ~acc & pend) | (ovf & ~{N{bus.ovf_clr}});
    end

    always_comb begin
        int unsigned idx;
        idx = 0;
        win = '0;
        any = 1'b0;
        for (int unsigned k = 0; k < NU; k++) begin
            idx = (32'(lg) + 32'd1 + k) % NU;
            if (!any && pend[idx]) begin
                any = 1'b1;
                win = IW'(idx);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st    <= IDLE;
            valid <= 1'b0;
            id    <= '0;
            lg    <= IW'(N - 1);
        end else begin
            st    <= st_nx;
            valid <= valid_nx;
            id    <= id_nx;
            lg    <= lg_nx;
        end
    end

    always_comb begin
        st_nx    = st;
        valid_nx = valid;
        id_nx    = id;
        lg_nx    = lg;
        case (st)
            IDLE: begin
                if (any) begin
                    id_nx    = win;
                    valid_nx = 1'b1;
                    st_nx    = OFFER;
                end
            end
            OFFER: begin
                if (bus.ev_ready) begin
                    lg_nx    = id;
                    valid_nx = 1'b0;
                    st_nx    = IDLE;
                end
            end
            default: begin
                st_nx    = IDLE;
                valid_nx = 1'b0;
            end
        endcase
    end

    assign bus.ev_valid = valid;
    assign bus.ev_id    = id;
    assign bus.pend     = pend;
    assign bus.ovf      = ovf;
endmodule

// File: tb/tb_edge_event_arbiter.sv
// Randomized and directed bench for edge_event_arbiter, compared every cycle against a
// behavioural model of delayed inputs, pending events and a round-robin consumer queue.
module tb_edge_event_arbiter;
    localparam int N  = 4;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    edge_event_arbiter_if #(.N(N), .IW(IW)) b ();
    edge_event_arbiter #(.N(N), .IW(IW)) dut (.clk(clk), .rst(rst), .bus(b));

    int n_tests = 0;
    int n_fail  = 0;
    int acc_log[$];

    // Model: d1/d2 are the input as seen one and two clocks ago, lvl the last sampled level.
    logic [N-1:0] m_d1, m_d2, m_lvl, m_pend, m_ovf;
    logic         m_valid;
    int           m_id, m_lg;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_d1 = '0; m_d2 = '0; m_lvl = '0; m_pend = '0; m_ovf = '0;
        m_valid = 1'b0; m_id = 0; m_lg = N - 1;
    endtask

    task automatic model_step(input logic t, input logic [N-1:0] x, input logic r, input logic c);
        logic [N-1:0] rise, old, set;
        bit a;
        old  = m_pend;
        set  = '0;
        rise = t ? (m_d2 & ~m_lvl) : '0;
        if (t) m_lvl = m_d2;
        for (int ch = 0; ch < N; ch++) begin
            a = m_valid && r && (m_id == ch);
            if (rise[ch]) begin
                if (!a && old[ch]) set[ch] = 1'b1;
                m_pend[ch] = 1'b1;
            end else if (a) begin
                m_pend[ch] = 1'b0;
            end
        end
        m_ovf = set | (c ? '0 : m_ovf);
        if (m_valid) begin
            if (r) begin
                m_lg    = m_id;
                m_valid = 1'b0;
            end
        end else if (old != '0) begin
            for (int k = 1; k <= N; k++) begin
                if (old[(m_lg + k) % N]) begin
                    m_id = (m_lg + k) % N;
                    break;
                end
            end
            m_valid = 1'b1;
        end
        m_d2 = m_d1;
        m_d1 = x;
    endtask

    task automatic step(input logic t, input logic [N-1:0] x, input logic r, input logic c);
        b.tick = t; b.in = x; b.ev_ready = r; b.ovf_clr = c;
        #1;
        if (b.ev_valid && r) acc_log.push_back(int'(b.ev_id));
        @(posedge clk);
        model_step(t, x, r, c);
        #1;
        chk("ev_valid", 32'(b.ev_valid), 32'(m_valid));
        chk("ev_id",    32'(b.ev_id),    32'(m_id));
        chk("pend",     32'(b.pend),     32'(m_pend));
        chk("ovf",      32'(b.ovf),      32'(m_ovf));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_valid", 32'(b.ev_valid), 32'd0);
        chk("rst_id",    32'(b.ev_id),    32'd0);
        chk("rst_pend",  32'(b.pend),     32'd0);
        chk("rst_ovf",   32'(b.ovf),      32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [N-1:0] x;
        int period;
        b.tick = 1'b0; b.in = '0; b.ev_ready = 1'b0; b.ovf_clr = 1'b0;
        model_reset();
        @(posedge clk);
        #1;

        // Reset with all inputs high mid-stream, then four ordered events.
        b.in = 4'b1111;
        do_reset();
        acc_log.delete();
        for (int j = 0; j < 20; j++) step(1'b1, 4'b1111, 1'b1, 1'b0);
        chk("rst_ev_count", 32'(acc_log.size()), 32'd4);
        for (int j = 0; j < 4; j++)
            if (j < acc_log.size()) chk("rst_ev_order", 32'(acc_log[j]), 32'(j));

        // Tick gating: short pulse between ticks is missed, long hold yields one event.
        for (int j = 0; j < 6; j++) step(1'b1, '0, 1'b1, 1'b0);
        acc_log.delete();
        for (int j = 0; j < 16; j++)
            step(j % 8 == 0, (j >= 2 && j <= 4) ? 4'b1000 : 4'b0000, 1'b1, 1'b0);
        chk("pulse_ev_count", 32'(acc_log.size()), 32'd0);
        for (int j = 0; j < 64; j++)
            step(j % 8 == 0, (j < 40) ? 4'b1000 : 4'b0000, 1'b1, 1'b0);
        chk("hold_ev_count", 32'(acc_log.size()), 32'd1);
        if (acc_log.size() > 0) chk("hold_ev_id", 32'(acc_log[0]), 32'd3);

        // Backpressure: second edge on offered channel overflows; clear; set beats clear.
        for (int j = 0; j < 4; j++) step(1'b1, '0, 1'b0, 1'b0);
        for (int j = 0; j < 5; j++) step(1'b1, 4'b0010, 1'b0, 1'b0);
        for (int j = 0; j < 3; j++) step(1'b1, 4'b0000, 1'b0, 1'b0);
        for (int j = 0; j < 4; j++) step(1'b1, 4'b0010, 1'b0, 1'b0);
        chk("bp_valid", 32'(b.ev_valid), 32'd1);
        chk("bp_id",    32'(b.ev_id),    32'd1);
        chk("bp_ovf1",  32'(b.ovf[1]),   32'd1);
        step(1'b1, 4'b0010, 1'b0, 1'b1);
        chk("clr_ovf", 32'(b.ovf), 32'd0);
        for (int j = 0; j < 3; j++) step(1'b1, 4'b0000, 1'b0, 1'b0);
        step(1'b1, 4'b0010, 1'b0, 1'b0);
        step(1'b1, 4'b0010, 1'b0, 1'b0);
        step(1'b1, 4'b0010, 1'b0, 1'b1);
        chk("set_beats_clr", 32'(b.ovf[1]), 32'd1);
        for (int j = 0; j < 8; j++) step(1'b1, 4'b0000, 1'b1, 1'b1);

        // Randomized phases with varying tick rates, backpressure and a mid-stream reset.
        x = '0;
        for (int blk = 0; blk < 6; blk++) begin
            period = (blk % 2 == 0) ? 1 : int'($urandom_range(2, 9));
            for (int j = 0; j < 500; j++) begin
                for (int ch = 0; ch < N; ch++)
                    if ($urandom_range(0, 15) == 0) x[ch] = ~x[ch];
                step((j % period) == 0, x, $urandom_range(0, 9) < 7,
                     $urandom_range(0, 31) == 0);
                if (blk == 3 && j == 250) do_reset();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
